// File: rtl/prm_scan_pkg.sv
// Shared types and width helpers for the PRM edge-scan controller.
package prm_scan_pkg;

    localparam int unsigned CODE_W_DEF     = 15;
    localparam int unsigned GROUP_W_DEF    = 16;
    localparam int unsigned NUM_GROUPS_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2
    } scan_state_e;

    // Group index width
    function automatic int unsigned idx_w(input int unsigned num_groups);
        return $clog2(num_groups);
    endfunction

    // Running-total width, sized to hold every edge of every group blocked
    function automatic int unsigned tot_w(input int unsigned num_groups,
                                          input int unsigned group_w);
        return $clog2(num_groups * group_w) + 1;
    endfunction

endpackage

// File: rtl/prm_popcount.sv
// Combinational population count of one checker group's edge mask.
module prm_popcount #(
    parameter int unsigned GROUP_W = 16,
    parameter int unsigned CNT_W   = $clog2(GROUP_W) + 1
) (
    input  logic [GROUP_W-1:0] bits,
    output logic [CNT_W-1:0]   count_c
);

    always_comb begin
        count_c = '0;
        for (int i = 0; i < int'(GROUP_W); i++) begin
            count_c = count_c + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Walks every checker group for one configuration code and streams
// per-group edge masks with a running blocked-edge total.
module prm_edge_scan_ctrl
    import prm_scan_pkg::*;
#(
    parameter int unsigned CODE_W     = CODE_W_DEF,
    parameter int unsigned GROUP_W    = GROUP_W_DEF,
    parameter int unsigned NUM_GROUPS = NUM_GROUPS_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [CODE_W-1:0]                         in_code,
    input  logic                                      abort,
    output logic [CODE_W-1:0]                         chk_code,
    output logic [idx_w(NUM_GROUPS)-1:0]              chk_grp,
    input  logic [GROUP_W-1:0]                        chk_mask,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [idx_w(NUM_GROUPS)-1:0]              out_grp,
    output logic [GROUP_W-1:0]                        out_mask,
    output logic                                      out_last,
    output logic [tot_w(NUM_GROUPS, GROUP_W)-1:0]     out_total,
    output logic                                      busy
);

    localparam int unsigned IDX_W = idx_w(NUM_GROUPS);
    localparam int unsigned TOT_W = tot_w(NUM_GROUPS, GROUP_W);
    localparam int unsigned POP_W = $clog2(GROUP_W) + 1;

    scan_state_e        state_q, state_d;
    logic [CODE_W-1:0]  code_q;
    logic [IDX_W-1:0]   grp_cnt;
    logic [TOT_W-1:0]   total_q;
    logic [POP_W-1:0]   pop_c;
    logic [TOT_W-1:0]   sum_c;
    logic               last_grp_c;
    logic               accept_c;
    logic               cap_c;
    logic               abort_c;

    prm_popcount #(
        .GROUP_W (GROUP_W),
        .CNT_W   (POP_W)
    ) u_popcount (
        .bits    (chk_mask),
        .count_c (pop_c)
    );

    assign chk_code   = code_q;
    assign chk_grp    = grp_cnt;
    assign last_grp_c = (grp_cnt == IDX_W'(NUM_GROUPS - 1));
    assign sum_c      = total_q + TOT_W'(pop_c);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; abort outranks capture and drain
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        cap_c    = 1'b0;
        abort_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    abort_c = 1'b1;
                    state_d = ST_IDLE;
                end else if (!out_valid || out_ready) begin
                    cap_c = 1'b1;
                    if (last_grp_c) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    abort_c = 1'b1;
                    state_d = ST_IDLE;
                end else if (out_valid && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, group walk and output beat register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            code_q    <= '0;
            grp_cnt   <= '0;
            total_q   <= '0;
            out_valid <= 1'b0;
            out_grp   <= '0;
            out_mask  <= '0;
            out_last  <= 1'b0;
            out_total <= '0;
        end else begin
            in_ready <= (state_d == ST_IDLE);
            busy     <= (state_d != ST_IDLE);
            if (accept_c) begin
                code_q  <= in_code;
                grp_cnt <= '0;
                total_q <= '0;
            end
            if (cap_c) begin
                out_valid <= 1'b1;
                out_grp   <= grp_cnt;
                out_mask  <= chk_mask;
                out_last  <= last_grp_c;
                out_total <= sum_c;
                total_q   <= sum_c;
                if (!last_grp_c) begin
                    grp_cnt <= grp_cnt + IDX_W'(1);
                end
            end else if (abort_c || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// Directed bench for prm_edge_scan_ctrl with a transaction-level scoreboard.
module tb_prm_edge_scan_ctrl;

    localparam int unsigned CW = 15;
    localparam int unsigned GW = 16;
    localparam int unsigned NG = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_code = '0;
    logic          abort = 1'b0;
    logic [CW-1:0] chk_code;
    logic [1:0]    chk_grp;
    logic [GW-1:0] chk_mask;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [1:0]    out_grp;
    logic [GW-1:0] out_mask;
    logic          out_last;
    logic [6:0]    out_total;
    logic          busy;

    logic [GW-1:0] mask_tbl [NG];

    int checks = 0;
    int errors = 0;

    prm_edge_scan_ctrl #(.CODE_W(CW), .GROUP_W(GW), .NUM_GROUPS(NG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .abort(abort), .chk_code(chk_code), .chk_grp(chk_grp),
        .chk_mask(chk_mask), .out_valid(out_valid), .out_ready(out_ready),
        .out_grp(out_grp), .out_mask(out_mask), .out_last(out_last),
        .out_total(out_total), .busy(busy)
    );

    always #5 clk = ~clk;

    // Checker bank stand-in: per-scan table indexed by group
    assign chk_mask = mask_tbl[chk_grp];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a scan is a list of beats; output is valid from one edge after
    // acceptance until the last beat is consumed or the scan is aborted.
    bit      m_active = 0;
    int      m_age = 0;
    int      m_code = 0;
    int      q_grp[$];
    int      q_mask[$];
    int      q_tot[$];
    int      q_last[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_age = 0; m_code = 0;
            q_grp.delete(); q_mask.delete(); q_tot.delete(); q_last.delete();
        end else if (m_active) begin
            if (abort) begin
                m_active = 0;
                q_grp.delete(); q_mask.delete(); q_tot.delete(); q_last.delete();
            end else begin
                if (m_age >= 1 && out_ready) begin
                    void'(q_grp.pop_front()); void'(q_mask.pop_front());
                    void'(q_tot.pop_front()); void'(q_last.pop_front());
                    if (q_grp.size() == 0) m_active = 0;
                end
                m_age++;
            end
        end else if (in_valid) begin
            int run;
            run = 0;
            m_active = 1; m_age = 0; m_code = int'(in_code);
            for (int g = 0; g < int'(NG); g++) begin
                run += $countones(mask_tbl[g]);
                q_grp.push_back(g);
                q_mask.push_back(int'(mask_tbl[g]));
                q_tot.push_back(run);
                q_last.push_back(g == int'(NG) - 1 ? 1 : 0);
            end
        end
    end

    // Per-cycle comparison against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(!m_active));
            check("busy", 32'(busy), 32'(m_active));
            check("out_valid", 32'(out_valid), 32'(m_active && m_age >= 1));
            check("chk_code", 32'(chk_code), 32'(m_code));
            if (m_active && m_age >= 1 && q_grp.size() > 0) begin
                check("out_grp", 32'(out_grp), 32'(q_grp[0]));
                check("out_mask", 32'(out_mask), 32'(q_mask[0]));
                check("out_total", 32'(out_total), 32'(q_tot[0]));
                check("out_last", 32'(out_last), 32'(q_last[0]));
            end
        end
    end

    // Log of beats the consumer actually took, for literal expectations
    int log_grp[$];
    int log_tot[$];
    int log_last[$];
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready && !abort) begin
            log_grp.push_back(int'(out_grp));
            log_tot.push_back(int'(out_total));
            log_last.push_back(int'(out_last));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        log_grp.delete(); log_tot.delete(); log_last.delete();
    endtask

    task automatic set_masks(input logic [GW-1:0] m0, input logic [GW-1:0] m1,
                             input logic [GW-1:0] m2, input logic [GW-1:0] m3);
        mask_tbl[0] = m0; mask_tbl[1] = m1; mask_tbl[2] = m2; mask_tbl[3] = m3;
    endtask

    task automatic request(input logic [CW-1:0] code);
        in_code = code; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string name);
        int cnt;
        cnt = 0;
        while (log_grp.size() < n && cnt < 200) begin
            tick(); cnt++;
        end
        check({name, "_timeout"}, 32'(log_grp.size() >= n), 32'd1);
    endtask

    task automatic wait_valid_grp(input int g, input string name);
        int cnt;
        cnt = 0;
        while (!(out_valid && int'(out_grp) == g) && cnt < 200) begin
            tick(); cnt++;
        end
        check({name, "_timeout"}, 32'(out_valid && int'(out_grp) == g), 32'd1);
    endtask

    task automatic check_log(input string name, input int t0, input int t1, input int t2, input int t3);
        int exp_t[4];
        exp_t = '{t0, t1, t2, t3};
        check({name, "_count"}, 32'(log_grp.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_grp.size(); i++) begin
            check({name, "_grp"}, 32'(log_grp[i]), 32'(i));
            check({name, "_tot"}, 32'(log_tot[i]), 32'(exp_t[i]));
            check({name, "_last"}, 32'(log_last[i]), 32'(i == 3));
        end
    endtask

    initial begin
        set_masks(16'h0001, 16'h0000, 16'hFFFF, 16'h8000);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_total", 32'(out_total), 32'd0);

        // Full scan, consumer always ready; first beat two cycles after acceptance
        clear_log();
        out_ready = 1'b1;
        request(15'h1A2B);
        check("lat_c1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_c2_valid", 32'(out_valid), 32'd1);
        check("lat_c2_grp", 32'(out_grp), 32'd0);
        wait_beats(4, "scan1");
        check("scan1_in_ready_after", 32'(in_ready), 32'd1);
        check_log("scan1", 1, 1, 17, 18);

        // Backpressure at grp 1 plus an ignored request mid-scan
        clear_log();
        request(15'h1A2B);
        wait_valid_grp(1, "scan2_g1");
        out_ready = 1'b0;
        in_code = 15'h7FFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("scan2_code_kept", 32'(chk_code), 32'h1A2B);
        tick(); tick();
        check("scan2_held_grp", 32'(out_grp), 32'd1);
        check("scan2_held_tot", 32'(out_total), 32'd1);
        out_ready = 1'b1;
        wait_beats(4, "scan2");
        check_log("scan2", 1, 1, 17, 18);
        tick();

        // Abort while grp 1 is shown and grp 2 would be captured
        clear_log();
        request(15'h0123);
        wait_valid_grp(1, "scan3_g1");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_beats", 32'(log_grp.size()), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_noeffect", 32'(in_ready), 32'd1);

        // Reset mid-scan, then a fresh scan under random backpressure
        clear_log();
        request(15'h5555);
        tick(); tick();
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_zero", 32'({out_grp, out_mask, out_total, out_last, chk_code, chk_grp, busy}), 32'd0);
        tick();
        rst = 1'b0;
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        clear_log();
        set_masks(16'h00FF, 16'h0F0F, 16'h0000, 16'hFFFF);
        request(15'h2222);
        for (int i = 0; i < 20; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        wait_beats(4, "scan4");
        check_log("scan4", 8, 16, 16, 32);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prm_edge_scan_ctrl.md
PRM_EDGE_SCAN_CTRL -- requirements
Module: prm_edge_scan_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 15, width of the obstacle/configuration code (bits A..O) fed to edge checkers.
REQ-002 SHALL have parameter GROUP_W, default 16, number of edge_mask bits returned by the checker bank per group.
REQ-003 SHALL have parameter NUM_GROUPS, default 32, number of checker groups per scan (power of two, >=2).
REQ-004 SHALL have ports, in this order:
  clk  in  1  sole clock, rising edge.
  rst  in  1  asynchronous active-high reset.
  in_valid  in  1  scan request.
  in_ready  out  1  controller can accept a request.
  in_code  in  CODE_W  code to check.
  abort  in  1  synchronous scan cancel.
  chk_code  out  CODE_W  code driven to the combinational checker bank.
  chk_grp  out  log2(NUM_GROUPS)  group select to the checker bank.
  chk_mask  in  GROUP_W  edge_mask bits of the selected group, same cycle.
  out_valid  out  1  result beat valid.
  out_ready  in  1  consumer accepts beat.
  out_grp  out  log2(NUM_GROUPS)  group index of beat.
  out_mask  out  GROUP_W  edge_mask bits of that group.
  out_last  out  1  beat is final group.
  out_total  out  log2(NUM_GROUPS*GROUP_W)+1  running count of blocked edges, including this beat.
  busy  out  1  scan in progress.

Function
REQ-005 SHALL implement states IDLE, SCAN, FLUSH.
REQ-006 IDLE: in_ready=1, busy=0; on in_valid SHALL latch in_code into code_q, clear grp_cnt and total_q, go to SCAN next cycle.
REQ-007 chk_code SHALL equal code_q at all times; chk_grp SHALL equal grp_cnt.
REQ-008 SCAN: a capture occurs in any cycle where out register is empty or out_ready=1.
REQ-009 On capture SHALL load out_mask=chk_mask, out_grp=grp_cnt, out_last=(grp_cnt==NUM_GROUPS-1), out_total=total_q+popcount(chk_mask), set out_valid=1, update total_q to that sum, increment grp_cnt.
REQ-010 Capture of the last group SHALL move to FLUSH; grp_cnt SHALL NOT wrap within a scan.
REQ-011 In SCAN with out_valid=1 and out_ready=0, out_* SHALL hold stable and grp_cnt SHALL not advance.
REQ-012 out_valid SHALL clear on out_ready with no new capture in the same cycle.
REQ-013 FLUSH: when the last beat is accepted, SHALL return to IDLE (in_ready=1 the following cycle).
REQ-014 Throughput: one beat per cycle with out_ready held high; first beat valid 2 cycles after request acceptance; scan occupies NUM_GROUPS+1 cycles from acceptance to last-beat valid.
REQ-015 in_ready SHALL be 0 in SCAN and FLUSH; in_valid there SHALL be ignored.
REQ-016 abort in SCAN or FLUSH SHALL clear out_valid and return to IDLE next cycle; abort has priority over capture; abort in IDLE has no effect.
REQ-017 busy SHALL be 1 in SCAN and FLUSH.
REQ-018 out_total SHALL never overflow (width covers NUM_GROUPS*GROUP_W).

Reset
REQ-019 rst SHALL asynchronously force IDLE, in_ready=1 (after release), out_valid=0, busy=0, out_last=0, and zero code_q, grp_cnt, total_q, out_mask, out_grp, out_total.
REQ-020 Reset mid-scan SHALL discard the scan with no further beats emitted.

Structure
REQ-021 State enum, CODE_W default, and derived index/total widths SHALL live in package prm_scan_pkg.
REQ-022 Population count SHALL be a sub-module prm_popcount (combinational, GROUP_W parameter).

Verification (NUM_GROUPS=4, GROUP_W=16)
REQ-023 Request code 15'h1A2B, checker returns 16'h0001,16'h0000,16'hFFFF,16'h8000, out_ready=1 -> beats grp 0..3, totals 1,1,17,18, out_last only on grp 3, in_ready=1 one cycle after.
REQ-024 Same scan with out_ready low for 3 cycles at grp 1 -> grp 1 beat held stable, no grp skipped, totals unchanged.
REQ-025 in_valid pulsed with code 15'h7FFF during SCAN -> ignored, code_q stays 15'h1A2B.
REQ-026 abort asserted on grp 2 capture cycle -> no grp 2 beat, out_valid=0 and IDLE next cycle.
REQ-027 rst asserted mid-SCAN -> out_valid=0 immediately, all outputs zero, new request afterwards restarts from grp 0 with total 0.
